// File: rtl/cellrv32_rst_gen.sv
// System reset generator: external reset filter, internal reset stretcher and reset-cause tracking.
// Define CELLRV32_RST_SWREQ_EN to add the software reset request input sw_rstn_i (cause code 11).
`timescale 1ns/100ps

module cellrv32_rst_gen #(
    parameter int unsigned EXT_FILTER_LEN = 4,
    parameter int unsigned RST_STRETCH    = 16
) (
    input  logic       clk_i,
    input  logic       rstn_ext_i,
    input  logic       wdt_rstn_i,
    input  logic       dbg_rstn_i,
`ifdef CELLRV32_RST_SWREQ_EN
    input  logic       sw_rstn_i,
`endif
    output logic       rstn_ext_o,
    output logic       rstn_int_o,
    output logic [1:0] rst_cause_o,
    output logic       rst_busy_o
);

    localparam int unsigned CntW = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(RST_STRETCH - 1);

    typedef enum logic [1:0] {
        StReset,
        StHold,
        StRun
    } state_e;

    logic [EXT_FILTER_LEN-1:0] r_filter;
    state_e                    r_state;
    logic [CntW-1:0]           r_cnt;
    logic                      r_int;
    logic [1:0]                r_cause;
    logic                      r_busy;

    state_e                    w_state_nxt;
    logic [CntW-1:0]           w_cnt_nxt;
    logic                      w_int_nxt;
    logic [1:0]                w_cause_nxt;
    logic                      w_wdt_req;
    logic                      w_dbg_req;
    logic                      w_sw_req;
    logic                      w_any_req;
    logic [1:0]                w_req_cause;
    logic                      w_ext_ok;

    assign w_wdt_req = ~wdt_rstn_i;
    assign w_dbg_req = ~dbg_rstn_i;
`ifdef CELLRV32_RST_SWREQ_EN
    assign w_sw_req  = ~sw_rstn_i;
`else
    assign w_sw_req  = 1'b0;
`endif
    assign w_any_req = w_wdt_req | w_dbg_req | w_sw_req;
    assign w_ext_ok  = &r_filter;

    // Fixed priority: WDT over debugger over software.
    always_comb begin
        w_req_cause = 2'b00;
        if (w_wdt_req) begin
            w_req_cause = 2'b01;
        end else if (w_dbg_req) begin
            w_req_cause = 2'b10;
        end else if (w_sw_req) begin
            w_req_cause = 2'b11;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_int_nxt   = r_int;
        w_cause_nxt = r_cause;
        unique case (r_state)
            StReset: begin
                if (w_ext_ok) begin
                    w_state_nxt = StHold;
                    w_cnt_nxt   = CntLoad;
                end
            end
            StHold: begin
                // A request during hold restarts the stretch from this cycle.
                if (w_any_req) begin
                    w_cnt_nxt   = CntLoad;
                    w_cause_nxt = w_req_cause;
                end else if (r_cnt == '0) begin
                    w_state_nxt = StRun;
                    w_int_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StRun: begin
                if (w_any_req) begin
                    w_state_nxt = StHold;
                    w_cnt_nxt   = CntLoad;
                    w_int_nxt   = 1'b0;
                    w_cause_nxt = w_req_cause;
                end
            end
            default: begin
                w_state_nxt = StReset;
                w_int_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_ext_i) begin
        if (!rstn_ext_i) begin
            r_filter <= '0;
            r_state  <= StReset;
            r_cnt    <= '0;
            r_int    <= 1'b0;
            r_cause  <= 2'b00;
            r_busy   <= 1'b1;
        end else begin
            r_filter <= {r_filter[EXT_FILTER_LEN-2:0], 1'b1};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_int    <= w_int_nxt;
            r_cause  <= w_cause_nxt;
            r_busy   <= (w_state_nxt != StRun);
        end
    end

    assign rstn_ext_o  = w_ext_ok;
    assign rstn_int_o  = r_int;
    assign rst_cause_o = r_cause;
    assign rst_busy_o  = r_busy;

endmodule

// File: tb/tb_cellrv32_rst_gen.sv
// Self-checking bench for cellrv32_rst_gen: edge-count reference model plus directed scenarios.
`timescale 1ns/100ps

module tb_cellrv32_rst_gen;

    localparam int N = 4;
    localparam int S = 16;

    logic       clk = 1'b0;
    logic       rstn_ext_i = 1'b1;
    logic       wdt_rstn_i = 1'b1;
    logic       dbg_rstn_i = 1'b1;
`ifdef CELLRV32_RST_SWREQ_EN
    logic       sw_rstn_i = 1'b1;
`endif
    logic       rstn_ext_o;
    logic       rstn_int_o;
    logic [1:0] rst_cause_o;
    logic       rst_busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    cellrv32_rst_gen #(
        .EXT_FILTER_LEN(N),
        .RST_STRETCH   (S)
    ) u_dut (
        .clk_i      (clk),
        .rstn_ext_i (rstn_ext_i),
        .wdt_rstn_i (wdt_rstn_i),
        .dbg_rstn_i (dbg_rstn_i),
`ifdef CELLRV32_RST_SWREQ_EN
        .sw_rstn_i  (sw_rstn_i),
`endif
        .rstn_ext_o (rstn_ext_o),
        .rstn_int_o (rstn_int_o),
        .rst_cause_o(rst_cause_o),
        .rst_busy_o (rst_busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: k = edges since external release; the internal reset is
    // released S edges after the last load (first load at edge N+1, or a request).
    int         m_k = 0;
    int         m_load = N + 1;
    logic [1:0] m_cause = 2'b00;

    always @(posedge clk or negedge rstn_ext_i) begin
        if (!rstn_ext_i) begin
            m_k     = 0;
            m_load  = N + 1;
            m_cause = 2'b00;
        end else begin
            m_k = m_k + 1;
            // The FSM leaves RESET at edge N+1, so requests count from edge N+2.
            if (m_k >= N + 2) begin
                if (!wdt_rstn_i) begin
                    m_load = m_k; m_cause = 2'b01;
                end else if (!dbg_rstn_i) begin
                    m_load = m_k; m_cause = 2'b10;
                end
`ifdef CELLRV32_RST_SWREQ_EN
                else if (!sw_rstn_i) begin
                    m_load = m_k; m_cause = 2'b11;
                end
`endif
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cmp_ext", int'(rstn_ext_o), int'(m_k >= N));
        check("cmp_int", int'(rstn_int_o), int'(m_k >= m_load + S));
        check("cmp_busy", int'(rst_busy_o), int'(!(m_k >= m_load + S)));
        check("cmp_cause", int'(rst_cause_o), int'(m_cause));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Edges until rstn_int_o rises, counted from the current edge; bounded.
    task automatic wait_release(output int n);
        n = 0;
        while (rstn_int_o == 1'b0 && n < 200) begin
            step();
            n++;
        end
    endtask

    // Called just before edge 1 with rstn_ext_i high.
    task automatic power_up(input bit dbg_in_reset);
        if (dbg_in_reset) dbg_rstn_i = 1'b0;
        repeat (3) step();
        check("pwr_ext_e3", int'(rstn_ext_o), 0);
        step();
        check("pwr_ext_e4", int'(rstn_ext_o), 1);
        step();
        dbg_rstn_i = 1'b1;
        repeat (15) step();
        check("pwr_int_e20", int'(rstn_int_o), 0);
        check("pwr_busy_e20", int'(rst_busy_o), 1);
        step();
        check("pwr_int_e21", int'(rstn_int_o), 1);
        check("pwr_busy_e21", int'(rst_busy_o), 0);
        check("pwr_cause", int'(rst_cause_o), 0);
    endtask

    int n;

    initial begin
        #1 rstn_ext_i = 1'b0;
        #1;
        check("rst_ext", int'(rstn_ext_o), 0);
        check("rst_int", int'(rstn_int_o), 0);
        check("rst_busy", int'(rst_busy_o), 1);
        check("rst_cause", int'(rst_cause_o), 0);
        repeat (10) step();
        rstn_ext_i = 1'b1;
        power_up(1'b0);

        // WDT one-cycle bite
        repeat (3) step();
        wdt_rstn_i = 1'b0;
        step();
        wdt_rstn_i = 1'b1;
        check("wdt_int_low", int'(rstn_int_o), 0);
        check("wdt_cause", int'(rst_cause_o), 1);
        check("wdt_ext_high", int'(rstn_ext_o), 1);
        wait_release(n);
        check("wdt_hold_len", n, S);

        // Simultaneous WDT+debugger, then debugger retrigger at counter 5
        repeat (3) step();
        wdt_rstn_i = 1'b0;
        dbg_rstn_i = 1'b0;
        step();
        wdt_rstn_i = 1'b1;
        dbg_rstn_i = 1'b1;
        check("simul_cause", int'(rst_cause_o), 1);
        repeat (10) step();
        dbg_rstn_i = 1'b0;
        step();
        dbg_rstn_i = 1'b1;
        check("retrig_cause", int'(rst_cause_o), 2);
        wait_release(n);
        check("retrig_hold_len", n, S);

        // Level debugger request for 40 cycles
        repeat (3) step();
        dbg_rstn_i = 1'b0;
        repeat (40) step();
        check("level_int_low", int'(rstn_int_o), 0);
        dbg_rstn_i = 1'b1;
        wait_release(n);
        check("level_hold_len", n, S);

        // Short external pulse during HOLD
        repeat (3) step();
        wdt_rstn_i = 1'b0;
        step();
        wdt_rstn_i = 1'b1;
        repeat (5) step();
        rstn_ext_i = 1'b0;
        #1;
        check("pulse_ext", int'(rstn_ext_o), 0);
        check("pulse_int", int'(rstn_int_o), 0);
        check("pulse_cause", int'(rst_cause_o), 0);
        #1.5;
        rstn_ext_i = 1'b1;
        power_up(1'b1);

`ifdef CELLRV32_RST_SWREQ_EN
        repeat (3) step();
        sw_rstn_i = 1'b0;
        step();
        sw_rstn_i = 1'b1;
        check("sw_cause", int'(rst_cause_o), 3);
        wait_release(n);
        check("sw_hold_len", n, S);
        repeat (3) step();
        sw_rstn_i = 1'b0;
        wdt_rstn_i = 1'b0;
        step();
        sw_rstn_i = 1'b1;
        wdt_rstn_i = 1'b1;
        check("sw_wdt_cause", int'(rst_cause_o), 1);
        wait_release(n);
        check("sw_wdt_hold_len", n, S);
`endif

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
